// File: rtl/alpha_pkg.sv
// Shared constants for the RGB565 alpha blender and the alpha controller.
// Alpha is a 9-bit weight in 0..ALPHA_MAX; blending divides by ALPHA_MAX with a shift.
package alpha_pkg;

  localparam int ALPHA_W       = 9;
  localparam int ALPHA_MAX     = 256;
  localparam int ALPHA_SHIFT   = 8;
  localparam int BLEND_LATENCY = 3;

  localparam int R_W   = 5;
  localparam int G_W   = 6;
  localparam int B_W   = 5;
  localparam int R_LSB = 11;
  localparam int G_LSB = 5;
  localparam int B_LSB = 0;

  typedef logic [ALPHA_W-1:0] alpha_t;

  // Requests above full weight saturate to full weight.
  function automatic alpha_t alpha_clamp(input alpha_t a);
    return (a > alpha_t'(ALPHA_MAX)) ? alpha_t'(ALPHA_MAX) : a;
  endfunction

endpackage

// File: rtl/alpha_blend_chan.sv
// One colour channel of the blender: stage-2 weighted products, stage-3 sum and scale.
// The sum never exceeds (2^W-1)*ALPHA_MAX, so W+ALPHA_SHIFT bits hold it exactly.
module alpha_blend_chan
  import alpha_pkg::*;
#(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_mul,
  input  logic         en_sum,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  alpha_t       alpha,
  input  alpha_t       inv_alpha,
  output logic [W-1:0] result
);

  localparam int PROD_W = W + ALPHA_SHIFT;

  logic [PROD_W-1:0] prod_a;
  logic [PROD_W-1:0] prod_b;
  logic [PROD_W-1:0] sum;

  always_ff @(posedge clk) begin
    if (en_mul) begin
      prod_a <= PROD_W'(a) * PROD_W'(alpha);
      prod_b <= PROD_W'(b) * PROD_W'(inv_alpha);
    end
  end

  assign sum = prod_a + prod_b;

  // Output holds its last value while the stage is idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result <= '0;
    end else if (en_sum) begin
      result <= sum[PROD_W-1:ALPHA_SHIFT];
    end
  end

endmodule

// File: rtl/alpha_blend_rgb565.sv
// Three-stage RGB565 alpha blender: out = ((256-a)*B + a*A) >> 8 per channel.
// alpha is taken from a shadow register that only changes on frame_start.
module alpha_blend_rgb565
  import alpha_pkg::*;
#(
  parameter logic [ALPHA_W-1:0] ALPHA_INIT = 9'd127
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ALPHA_W-1:0] alpha_data,
  input  logic               frame_start,
  input  logic               in_valid,
  input  logic [15:0]        pix_a,
  input  logic [15:0]        pix_b,
  output logic               out_valid,
  output logic [15:0]        out_data
);

  alpha_t                   alpha_s;
  alpha_t                   alpha_eff;
  alpha_t                   alpha_1;
  alpha_t                   inv_alpha_1;
  logic [15:0]              pix_a_1;
  logic [15:0]              pix_b_1;
  logic [BLEND_LATENCY-1:0] vld;

  // A pixel arriving with frame_start already uses the new weight.
  assign alpha_eff = frame_start ? alpha_clamp(alpha_data) : alpha_s;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alpha_s <= ALPHA_INIT;
      vld     <= '0;
    end else begin
      if (frame_start) begin
        alpha_s <= alpha_eff;
      end
      vld <= {vld[BLEND_LATENCY-2:0], in_valid};
    end
  end

  // NOTE: datapath registers carry no reset; the valid bits alone decide
  // whether their contents are ever observed.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      pix_a_1     <= pix_a;
      pix_b_1     <= pix_b;
      alpha_1     <= alpha_eff;
      inv_alpha_1 <= alpha_t'(ALPHA_MAX) - alpha_eff;
    end
  end

  alpha_blend_chan #(.W(R_W)) u_chan_r (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_mul    (vld[0]),
    .en_sum    (vld[1]),
    .a         (pix_a_1[R_LSB +: R_W]),
    .b         (pix_b_1[R_LSB +: R_W]),
    .alpha     (alpha_1),
    .inv_alpha (inv_alpha_1),
    .result    (out_data[R_LSB +: R_W])
  );

  alpha_blend_chan #(.W(G_W)) u_chan_g (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_mul    (vld[0]),
    .en_sum    (vld[1]),
    .a         (pix_a_1[G_LSB +: G_W]),
    .b         (pix_b_1[G_LSB +: G_W]),
    .alpha     (alpha_1),
    .inv_alpha (inv_alpha_1),
    .result    (out_data[G_LSB +: G_W])
  );

  alpha_blend_chan #(.W(B_W)) u_chan_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_mul    (vld[0]),
    .en_sum    (vld[1]),
    .a         (pix_a_1[B_LSB +: B_W]),
    .b         (pix_b_1[B_LSB +: B_W]),
    .alpha     (alpha_1),
    .inv_alpha (inv_alpha_1),
    .result    (out_data[B_LSB +: B_W])
  );

  assign out_valid = vld[BLEND_LATENCY-1];

endmodule

// File: tb/tb_alpha_blend_rgb565.sv
// Bench for alpha_blend_rgb565: a per-cycle expectation timeline built from plain
// integer blending, compared every cycle, plus hand-computed literal vectors.
module tb_alpha_blend_rgb565;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [8:0]  alpha_data;
  logic        frame_start;
  logic        in_valid;
  logic [15:0] pix_a;
  logic [15:0] pix_b;
  logic        out_valid;
  logic [15:0] out_data;

  alpha_blend_rgb565 #(.ALPHA_INIT(9'd127)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .alpha_data  (alpha_data),
    .frame_start (frame_start),
    .in_valid    (in_valid),
    .pix_a       (pix_a),
    .pix_b       (pix_b),
    .out_valid   (out_valid),
    .out_data    (out_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected outputs indexed by the cycle in which they must be visible.
  bit          exp_valid [0:1023];
  logic [15:0] exp_data  [0:1023];
  bit          reset_at  [0:1023];
  int          alpha_m = 127;
  int          total = 0;
  int          bad = 0;
  logic [15:0] model_out = 16'h0000;

  function automatic logic [15:0] blend(int a, logic [15:0] fa, logic [15:0] fb);
    int r, g, b;
    r = ((256 - a) * int'(fb[15:11]) + a * int'(fa[15:11])) / 256;
    g = ((256 - a) * int'(fb[10:5])  + a * int'(fa[10:5]))  / 256;
    b = ((256 - a) * int'(fb[4:0])   + a * int'(fa[4:0]))   / 256;
    return 16'(r * 2048 + g * 32 + b);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Drive one cycle of inputs and record what the design must do with them.
  task automatic step(bit r, bit f, bit v, int a_req, logic [15:0] xa, logic [15:0] xb);
    int a;
    rst_n       = r;
    frame_start = f;
    in_valid    = v;
    alpha_data  = 9'(a_req);
    pix_a       = xa;
    pix_b       = xb;
    if (!r) begin
      for (int k = 1; k <= 3; k++) exp_valid[cyc + k] = 1'b0;
      reset_at[cyc + 1] = 1'b1;
      alpha_m = 127;
    end else begin
      a = f ? ((a_req > 256) ? 256 : a_req) : alpha_m;
      if (f) alpha_m = a;
      if (v) begin
        exp_valid[cyc + 3] = 1'b1;
        exp_data[cyc + 3]  = blend(a, xa, xb);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, int'(alpha_data), 16'h0, 16'h0);
  endtask

  // One pixel with a hand-computed result, checked three cycles later.
  task automatic lit(string name, int a_req, bit f, logic [15:0] xa, logic [15:0] xb,
                     logic [15:0] want);
    step(1'b1, f, 1'b1, a_req, xa, xb);
    step(1'b1, 1'b0, 1'b0, a_req, 16'h0, 16'h0);
    step(1'b1, 1'b0, 1'b0, a_req, 16'h0, 16'h0);
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    check({name, "_data"}, 32'(out_data), 32'(want));
    check({name, "_model"}, 32'(exp_data[cyc]), 32'(want));
  endtask

  always @(negedge clk) begin
    if (cyc >= 1) begin
      if (reset_at[cyc]) model_out = 16'h0000;
      if (exp_valid[cyc]) model_out = exp_data[cyc];
      check("out_valid", 32'(out_valid), 32'(exp_valid[cyc]));
      check("out_data", 32'(out_data), 32'(model_out));
    end
  end

  initial begin
    rst_n = 1'b0; frame_start = 1'b0; in_valid = 1'b0;
    alpha_data = 9'd0; pix_a = 16'h0; pix_b = 16'h0;
    step(1'b0, 1'b0, 1'b0, 0, 16'h0, 16'h0);
    step(1'b0, 1'b0, 1'b0, 0, 16'h0, 16'h0);
    check("reset_out_data", 32'(out_data), 32'h0);
    check("reset_out_valid", 32'(out_valid), 32'h0);

    lit("a0_passes_b",   0,   1'b1, 16'hFFFF, 16'h1234, 16'h1234);
    lit("a256_passes_a", 256, 1'b1, 16'hF800, 16'h07E0, 16'hF800);
    lit("a128_half",     128, 1'b1, 16'hFFFF, 16'h0000, 16'h7BEF);
    lit("alpha_held",    0,   1'b0, 16'hFFFF, 16'h0000, 16'h7BEF);
    step(1'b1, 1'b1, 1'b0, 0, 16'h0, 16'h0);
    lit("fs_no_pixel",   0,   1'b0, 16'hFFFF, 16'h0000, 16'h0000);
    lit("fs_bypass",     256, 1'b1, 16'hFFFF, 16'h0000, 16'hFFFF);
    lit("a300_clamped",  300, 1'b1, 16'hABCD, 16'h1234, 16'hABCD);
    lit("a64_mix",       64,  1'b1, 16'hF81F, 16'h07E0, 16'h3DE7);

    // Gap pattern 1,0,1,1,0 must reappear three cycles later.
    step(1'b1, 1'b1, 1'b1, 200, 16'hF81F, 16'h07E0);
    step(1'b1, 1'b0, 1'b0, 200, 16'h0000, 16'h0000);
    step(1'b1, 1'b0, 1'b1, 200, 16'h1357, 16'hFDB9);
    step(1'b1, 1'b0, 1'b1, 200, 16'h8421, 16'h7BDE);
    step(1'b1, 1'b0, 1'b0, 200, 16'h0000, 16'h0000);
    idle(4);

    // Reset mid-burst: in-flight pixels vanish and alpha returns to 127.
    step(1'b1, 1'b1, 1'b1, 0, 16'hFFFF, 16'h5555);
    step(1'b1, 1'b0, 1'b1, 0, 16'hAAAA, 16'h5555);
    step(1'b0, 1'b0, 1'b1, 0, 16'hFFFF, 16'h0000);
    lit("post_reset_alpha", 0, 1'b0, 16'hFFFF, 16'h0000, 16'h7BEF);

    // Back-to-back stream with two frame boundaries and periodic gaps.
    for (int i = 0; i < 24; i++) begin
      step(1'b1, (i == 0) || (i == 12), (i % 3) != 2,
           (i < 12) ? 77 : 180, 16'($urandom), 16'($urandom));
    end
    idle(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
